// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined N-operand signed adder tree feeding a saturating per-packet beat accumulator
module adder_tree_acc #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int N         = 27,
  parameter int RADIX     = 3,
  parameter int PIPELINE  = 1,
  parameter int ACC_W     = 24,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic signed [WIDTH_IN-1:0]  inputs [N],
  output logic                        out_valid,
  output logic signed [WIDTH_OUT-1:0] sum,
  output logic                        overflow
);
  function automatic int depth_of(input int n, input int r);
    int d;
    longint p;
    d = 0;
    p = 1;
    while (p < n) begin
      p = p * r;
      d++;
    end
    return d;
  endfunction
  localparam int TW = WIDTH_IN + $clog2(N) + 1;
  localparam int D  = depth_of(N, RADIX < 2 ? 2 : RADIX);
  localparam int P  = RADIX ** D;
  localparam int L  = PIPELINE != 0 ? D : 0;
  if (RADIX != 2 && RADIX != 3) begin : g_bad_radix
    $fatal(1, "adder_tree_acc: RADIX must be 2 or 3");
  end
  if (N < 1 || ACC_W < TW || ACC_W < WIDTH_OUT) begin : g_bad_width
    $fatal(1, "adder_tree_acc: need N >= 1 and ACC_W >= max(TW, WIDTH_OUT)");
  end
  // Leaves are zero-padded to RADIX**D so every level is a uniform RADIX-way reduction
  for (genvar k = 0; k <= D; k++) begin : g_l
    localparam int M = P / (RADIX ** k);
    logic signed [TW-1:0] v [M];
    if (k == 0) begin : g_leaf
      always_comb begin
        v = '{default: '0};
        for (int j = 0; j < N; j++) v[j] = TW'(inputs[j]);
      end
    end else begin : g_node
      logic signed [TW-1:0] s [M];
      always_comb begin
        s = '{default: '0};
        for (int j = 0; j < M; j++)
          for (int c = 0; c < RADIX; c++) s[j] = s[j] + g_l[k-1].v[RADIX*j+c];
      end
      if (PIPELINE != 0) begin : g_reg
        always_ff @(posedge clk) v <= s;
      end else begin : g_comb
        assign v = s;
      end
    end
  end
  logic signed [TW-1:0] t;
  logic [2:0] c_in, c_t;
  assign t    = g_l[D].v[0];
  assign c_in = {in_valid, in_valid & in_first, in_valid & in_last};
  if (L == 0) begin : g_nctl
    assign c_t = c_in;
  end else begin : g_ctl
    logic [2:0] p [L];
    always_ff @(posedge clk) begin
      if (rst) p <= '{default: '0};
      else begin
        p[0] <= c_in;
        for (int i = 1; i < L; i++) p[i] <= p[i-1];
      end
    end
    assign c_t = p[L-1];
  end
  logic signed [ACC_W-1:0]     acc, base, ext, acc_next;
  logic signed [ACC_W:0]       raw;
  logic                        acc_ovf, clip, ovf_next, oor;
  logic [ACC_W-WIDTH_OUT:0]    top;
  logic signed [WIDTH_OUT-1:0] res;
  always_comb begin
    base     = c_t[1] ? '0 : acc;
    ext      = ACC_W'(t);
    raw      = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
    clip     = raw[ACC_W] != raw[ACC_W-1];
    acc_next = clip ? (raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                    : raw[ACC_W-1:0];
    ovf_next = (!c_t[1] && acc_ovf) || clip;
    top      = acc_next[ACC_W-1:WIDTH_OUT-1];
    oor      = !(&top) && |top;
    res      = (oor && SATURATE != 0)
             ? (acc_next[ACC_W-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}} : {1'b0, {(WIDTH_OUT-1){1'b1}}})
             : acc_next[WIDTH_OUT-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= c_t[2] & c_t[0];
      if (c_t[2]) begin
        acc     <= c_t[0] ? '0 : acc_next;
        acc_ovf <= c_t[0] ? 1'b0 : ovf_next;
        if (c_t[0]) begin
          sum      <= res;
          overflow <= ovf_next | oor;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: drives a default instance and a RADIX=2/combinational/wrapping instance against a packet-level model
module tb_adder_tree_acc;
  localparam int N = 27;
  localparam int MAXC = 2048;
  logic clk = 0, rst = 1, in_valid = 0, in_first = 0, in_last = 0;
  logic signed [7:0] inputs [N];
  logic ov0, ov1, oo0, oo1;
  logic signed [15:0] os0, os1;
  always #5 clk = ~clk;
  adder_tree_acc dut0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .inputs(inputs), .out_valid(ov0), .sum(os0), .overflow(oo0));
  adder_tree_acc #(.RADIX(2), .PIPELINE(0), .SATURATE(0)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .inputs(inputs), .out_valid(ov1), .sum(os1), .overflow(oo1));
  typedef struct {int due; longint t; bit f; bit l;} beat_t;
  int lat [2] = '{3, 0};
  bit sat [2] = '{1'b1, 1'b0};
  beat_t pend [2][$];
  longint macc [2];
  bit movf [2], ex_v [2], ex_o [2];
  logic signed [15:0] ex_s [2];
  logic rec_ov [2][MAXC], rec_oo [2][MAXC], rec_ev [2][MAXC], rec_eo [2][MAXC];
  logic signed [15:0] rec_os [2][MAXC], rec_es [2][MAXC];
  int cyc, vec, err;

  // packet semantics: beat enters the accumulator lat cycles after it is accepted
  task automatic model_beat(input int d, input beat_t b);
    longint a;
    bit o, r;
    a = b.f ? b.t : macc[d] + b.t;
    o = b.f ? 1'b0 : movf[d];
    if (a > 8388607) begin a = 8388607; o = 1; end
    else if (a < -8388608) begin a = -8388608; o = 1; end
    if (b.l) begin
      r = a > 32767 || a < -32768;
      ex_v[d] = 1;
      ex_o[d] = o | r;
      if (!r) ex_s[d] = 16'(a);
      else if (sat[d]) ex_s[d] = a > 0 ? 16'sd32767 : -16'sd32768;
      else ex_s[d] = 16'(a);
      macc[d] = 0;
      movf[d] = 0;
    end else begin
      macc[d] = a;
      movf[d] = o;
    end
  endtask

  task automatic tick(input bit r, input bit v, input bit f, input bit l, input int val [N]);
    longint t;
    beat_t nb;
    t = 0;
    rst = r; in_valid = v; in_first = f; in_last = l;
    for (int i = 0; i < N; i++) begin
      inputs[i] = 8'(val[i]);
      t += val[i];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        pend[d].delete();
        macc[d] = 0; movf[d] = 0; ex_v[d] = 0; ex_s[d] = 0; ex_o[d] = 0;
      end else begin
        ex_v[d] = 0;
        if (v) begin
          nb.due = cyc + lat[d]; nb.t = t; nb.f = f; nb.l = l;
          pend[d].push_back(nb);
        end
        if (pend[d].size() > 0 && pend[d][0].due == cyc) model_beat(d, pend[d].pop_front());
      end
    end
    #1;
    rec_ov[0][cyc] = ov0; rec_os[0][cyc] = os0; rec_oo[0][cyc] = oo0;
    rec_ov[1][cyc] = ov1; rec_os[1][cyc] = os1; rec_oo[1][cyc] = oo1;
    for (int d = 0; d < 2; d++) begin
      rec_ev[d][cyc] = ex_v[d]; rec_es[d][cyc] = ex_s[d]; rec_eo[d][cyc] = ex_o[d];
    end
    cyc++;
  endtask

  task automatic beat(input bit r, input bit v, input bit f, input bit l, input int x);
    int a [N];
    foreach (a[i]) a[i] = x;
    tick(r, v, f, l, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int c0 = cyc;
    beat(1, 1, 1, 1, 5);
    beat(1, 0, 0, 0, 0);
    vec++;
    if ({ov0, os0, oo0, ov1, os1, oo1} !== 36'd0) begin
      err++;
      $display("FAIL reset: got %b/%0d/%b %b/%0d/%b, want all 0", ov0, os0, oo0, ov1, os1, oo1);
    end
    idle(5);
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL reset dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  task automatic test_single();
    int c0 = cyc, pulses = 0;
    beat(0, 1, 1, 1, 1);
    idle(6);
    for (int i = c0; i < cyc; i++) pulses += int'(rec_ov[0][i]);
    vec++;
    if (pulses != 1 || rec_ov[0][c0+3] !== 1'b1 || rec_os[0][c0+3] !== 16'sd27 || rec_ov[1][c0] !== 1'b1) begin
      err++;
      $display("FAIL single_v1: pulses=%0d sum=%0d dut1_v=%b, want 1 pulse at +3 sum=27 dut1_v=1", pulses,
        rec_os[0][c0+3], rec_ov[1][c0]);
    end
    c0 = cyc;
    beat(0, 1, 1, 1, -128);
    idle(5);
    vec++;
    if (rec_os[0][c0+3] !== 16'shF280 || rec_os[1][c0] !== 16'shF280 || rec_oo[0][c0+3] !== 1'b0) begin
      err++;
      $display("FAIL single_neg: got %h/%h ovf=%b, want f280/f280 ovf=0", rec_os[0][c0+3], rec_os[1][c0],
        rec_oo[0][c0+3]);
    end
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL single dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  task automatic test_packets();
    int c0 = cyc, pulses = 0;
    beat(0, 1, 1, 0, 127);
    beat(0, 1, 0, 0, 127);
    idle(1);
    beat(0, 1, 0, 1, 127);
    beat(0, 1, 0, 0, 5);
    beat(0, 1, 1, 0, 7);
    beat(0, 1, 0, 1, 7);
    idle(5);
    for (int i = c0; i < cyc; i++) pulses += int'(rec_ov[0][i]);
    vec++;
    if (pulses != 2 || rec_os[0][c0+6] !== 16'sd10287 || rec_os[0][c0+9] !== 16'sd378) begin
      err++;
      $display("FAIL packets: pulses=%0d sums=%0d,%0d, want 2 pulses 10287,378", pulses, rec_os[0][c0+6],
        rec_os[0][c0+9]);
    end
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL packets dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  task automatic test_saturate();
    int c0 = cyc;
    for (int i = 0; i < 10; i++) beat(0, 1, i == 0, i == 9, 127);
    beat(0, 1, 1, 1, 1);
    idle(5);
    vec++;
    if (rec_os[0][c0+12] !== 16'sd32767 || rec_oo[0][c0+12] !== 1'b1 || rec_os[1][c0+9] !== -16'sd31246
        || rec_oo[1][c0+9] !== 1'b1 || rec_os[0][c0+13] !== 16'sd27 || rec_oo[0][c0+13] !== 1'b0) begin
      err++;
      $display("FAIL saturate: got %0d/%b wrap %0d/%b next %0d/%b, want 32767/1 -31246/1 27/0",
        rec_os[0][c0+12], rec_oo[0][c0+12], rec_os[1][c0+9], rec_oo[1][c0+9], rec_os[0][c0+13], rec_oo[0][c0+13]);
    end
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL saturate dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0 = cyc;
    for (int v = 1; v <= 4; v++) beat(0, 1, 1, 1, v);
    idle(5);
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (rec_ov[0][c0+3+k] !== 1'b1 || rec_os[0][c0+3+k] !== 16'(27 * (k + 1))) begin
        err++;
        $display("FAIL b2b_%0d: got v=%b sum=%0d, want v=1 sum=%0d", k, rec_ov[0][c0+3+k], rec_os[0][c0+3+k],
          27 * (k + 1));
      end
    end
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL b2b dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0 = cyc, pulses = 0;
    beat(0, 1, 1, 0, 10);
    beat(0, 1, 0, 0, 10);
    beat(1, 0, 0, 0, 0);
    beat(0, 1, 1, 1, 2);
    idle(6);
    for (int i = c0; i < cyc; i++) pulses += int'(rec_ov[0][i]);
    vec++;
    if (pulses != 1 || rec_ov[0][c0+6] !== 1'b1 || rec_os[0][c0+6] !== 16'sd54) begin
      err++;
      $display("FAIL reset_mid: pulses=%0d sum=%0d, want 1 pulse sum=54", pulses, rec_os[0][c0+6]);
    end
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL reset_mid dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  task automatic test_random();
    int c0 = cyc;
    int a [N];
    for (int k = 0; k < 400; k++) begin
      foreach (a[i]) a[i] = int'($urandom_range(0, 255)) - 128;
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
        $urandom_range(0, 5) == 0, a);
    end
    idle(5);
    for (int i = c0; i < cyc; i++) for (int d = 0; d < 2; d++) begin
      vec++;
      if ({rec_ov[d][i], rec_os[d][i], rec_oo[d][i]} !== {rec_ev[d][i], rec_es[d][i], rec_eo[d][i]}) begin
        err++;
        $display("FAIL random dut%0d cyc%0d: got v=%0b sum=%0d ovf=%0b, want v=%0b sum=%0d ovf=%0b", d, i,
          rec_ov[d][i], rec_os[d][i], rec_oo[d][i], rec_ev[d][i], rec_es[d][i], rec_eo[d][i]);
      end
    end
  endtask

  initial begin
    cyc = 0; vec = 0; err = 0;
    for (int d = 0; d < 2; d++) begin
      macc[d] = 0; movf[d] = 0; ex_v[d] = 0; ex_s[d] = 0; ex_o[d] = 0;
    end
    foreach (inputs[i]) inputs[i] = '0;
    test_reset();
    test_single();
    test_packets();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
